rsa_modexp_ctrl: RTL and testbench

Square-and-multiply sequencer that computes result = base^exponent mod modulus. It drives one shared shift-add modular multiplier through that multiplier's ds/ready handshake, acting as the initiator side of that interface. It sits between the RSA top-level command interface and the multiplier, and issues all multiply and square operations sequentially.

---
 rtl/rsa_modexp_ctrl_if.sv | 30 +++
 rtl/rsa_modexp_ctrl.sv | 146 ++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_ctrl_if.sv
// Command side plus multiplier side of the modular exponentiation sequencer.
// The master modport is the sequencer; the slave modport is its environment (host and multiplier).
interface rsa_modexp_ctrl_if #(
    parameter int MPWID = 1024
);
    logic             start;
    logic [MPWID-1:0] base;
    logic [MPWID-1:0] exponent;
    logic [MPWID-1:0] modulus;
    logic             busy;
    logic             done;
    logic             err;
    logic [MPWID-1:0] result;
    logic [MPWID-1:0] mm_mpand;
    logic [MPWID-1:0] mm_mplier;
    logic [MPWID-1:0] mm_modulus;
    logic             mm_ds;
    logic             mm_ready;
    logic [MPWID-1:0] mm_product;

    modport master (
        input  start, base, exponent, modulus, mm_ready, mm_product,
        output busy, done, err, result, mm_mpand, mm_mplier, mm_modulus, mm_ds
    );

    modport slave (
        output start, base, exponent, modulus, mm_ready, mm_product,
        input  busy, done, err, result, mm_mpand, mm_mplier, mm_modulus, mm_ds
    );
endinterface

// File: rtl/rsa_modexp_ctrl.sv
// Square-and-multiply sequencer: result = base^exponent mod modulus via one shared multiplier.
// Each multiply/square costs >= 3 controller cycles plus multiplier latency; mm_ds holds until mm_ready.
module rsa_modexp_ctrl #(
    parameter int MPWID = 1024
) (
    input  logic                clk,
    input  logic                reset,
    rsa_modexp_ctrl_if.master   bus
);
    localparam logic [3:0] IDLE        = 4'd0;
    localparam logic [3:0] CHECK       = 4'd1;
    localparam logic [3:0] MUL_ISSUE   = 4'd2;
    localparam logic [3:0] MUL_WAIT_LO = 4'd3;
    localparam logic [3:0] MUL_WAIT_HI = 4'd4;
    localparam logic [3:0] SQR_CHK     = 4'd5;
    localparam logic [3:0] SQR_ISSUE   = 4'd6;
    localparam logic [3:0] SQR_WAIT_LO = 4'd7;
    localparam logic [3:0] SQR_WAIT_HI = 4'd8;
    localparam logic [3:0] NEXT        = 4'd9;
    localparam logic [3:0] DONE        = 4'd10;

    localparam logic [MPWID-1:0] ONE = {{(MPWID-1){1'b0}}, 1'b1};

    logic [3:0]       state;
    logic [MPWID-1:0] b_reg, e_reg, n_reg, r_reg;
    logic [MPWID-1:0] result_reg, mpand_reg, mplier_reg;
    logic             busy_reg, done_reg, err_reg, ds_reg;
    logic [MPWID-1:0] e_shr;

    assign e_shr = e_reg >> 1;

    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.err        = err_reg;
    assign bus.result     = result_reg;
    assign bus.mm_mpand   = mpand_reg;
    assign bus.mm_mplier  = mplier_reg;
    assign bus.mm_modulus = n_reg;
    assign bus.mm_ds      = ds_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            b_reg      <= '0;
            e_reg      <= '0;
            n_reg      <= '0;
            r_reg      <= '0;
            result_reg <= '0;
            mpand_reg  <= '0;
            mplier_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            ds_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        b_reg    <= bus.base;
                        e_reg    <= bus.exponent;
                        n_reg    <= bus.modulus;
                        r_reg    <= ONE;
                        err_reg  <= 1'b0;
                        busy_reg <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (n_reg == '0) begin
                        result_reg <= '0;
                        err_reg    <= 1'b1;
                        done_reg   <= 1'b1;
                        state      <= DONE;
                    end else if (n_reg == ONE || e_reg == '0) begin
                        result_reg <= (n_reg == ONE) ? '0 : ONE;
                        done_reg   <= 1'b1;
                        state      <= DONE;
                    end else if (e_reg[0]) begin
                        mpand_reg  <= r_reg;
                        mplier_reg <= b_reg;
                        ds_reg     <= 1'b1;
                        state      <= MUL_ISSUE;
                    end else begin
                        state <= SQR_CHK;
                    end
                end
                MUL_ISSUE: begin
                    if (bus.mm_ready) begin
                        ds_reg <= 1'b0;
                        state  <= MUL_WAIT_LO;
                    end
                end
                // ready is high while the multiplier idles, so wait for it to drop first
                MUL_WAIT_LO: if (!bus.mm_ready) state <= MUL_WAIT_HI;
                MUL_WAIT_HI: begin
                    if (bus.mm_ready) begin
                        r_reg <= bus.mm_product;
                        state <= SQR_CHK;
                    end
                end
                SQR_CHK: begin
                    e_reg <= e_shr;
                    if (e_shr == '0) begin
                        result_reg <= r_reg;
                        done_reg   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        mpand_reg  <= b_reg;
                        mplier_reg <= b_reg;
                        ds_reg     <= 1'b1;
                        state      <= SQR_ISSUE;
                    end
                end
                SQR_ISSUE: begin
                    if (bus.mm_ready) begin
                        ds_reg <= 1'b0;
                        state  <= SQR_WAIT_LO;
                    end
                end
                SQR_WAIT_LO: if (!bus.mm_ready) state <= SQR_WAIT_HI;
                SQR_WAIT_HI: begin
                    if (bus.mm_ready) begin
                        b_reg <= bus.mm_product;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (e_reg[0]) begin
                        mpand_reg  <= r_reg;
                        mplier_reg <= b_reg;
                        ds_reg     <= 1'b1;
                        state      <= MUL_ISSUE;
                    end else begin
                        state <= SQR_CHK;
                    end
                end
                DONE: begin
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed bench for rsa_modexp_ctrl with a latency-modelled multiplier and an arithmetic reference model.
module tb_rsa_modexp_ctrl;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rsa_modexp_ctrl_if #(.MPWID(W)) bus ();
    rsa_modexp_ctrl #(.MPWID(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // reference: repeated modular multiplication, nothing like square-and-multiply
    function automatic logic [W-1:0] model_exp(input logic [W-1:0] b, input logic [W-1:0] e,
                                               input logic [W-1:0] n);
        logic [63:0] r;
        if (n == '0) return '0;
        r = 64'd1 % 64'(n);
        for (int i = 0; i < int'(e); i++) r = (r * 64'(b)) % 64'(n);
        return W'(r);
    endfunction

    function automatic int model_ops(input logic [W-1:0] e, input logic [W-1:0] n);
        int pc = 0;
        int msb = 0;
        if (n <= 1 || e == '0) return 0;
        for (int i = 0; i < W; i++) begin
            if (e[i]) begin
                pc++;
                msb = i;
            end
        end
        return pc + msb;
    endfunction

    // multiplier stand-in: idle-high ready, fixed latency, optional one-time pre-accept stall
    logic [63:0] op_a, op_b, op_n;
    int  lat_cnt = 0;
    int  hold_cnt = 0;
    int  accepts = 0;
    bit  stall_req = 1'b0;
    bit  stall_used = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mm_ready   <= 1'b1;
            bus.mm_product <= '0;
            lat_cnt        <= 0;
            hold_cnt       <= 0;
        end else if (hold_cnt != 0) begin
            hold_cnt <= hold_cnt - 1;
            if (hold_cnt == 1) bus.mm_ready <= 1'b1;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                bus.mm_ready   <= 1'b1;
                bus.mm_product <= W'((op_a * op_b) % op_n);
            end
        end else if (stall_req && !stall_used) begin
            bus.mm_ready <= 1'b0;
            if (bus.mm_ds) begin
                hold_cnt   <= 4;
                stall_used <= 1'b1;
            end
        end else if (bus.mm_ds && bus.mm_ready) begin
            bus.mm_ready <= 1'b0;
            op_a         <= 64'(bus.mm_mpand);
            op_b         <= 64'(bus.mm_mplier);
            op_n         <= 64'(bus.mm_modulus);
            lat_cnt      <= 3;
            accepts      <= accepts + 1;
        end
    end

    logic [W-1:0] exp_r = '0;
    logic [W-1:0] exp_n = '0;
    logic         exp_err = 1'b0;
    int           done_count = 0;
    int           ds_run = 0;
    int           ds_run_max = 0;
    logic         prev_ds = 1'b0;
    logic [W-1:0] prev_a = '0, prev_b = '0;

    // every-cycle compare against the model
    always @(negedge clk) begin
        if (reset) begin
            prev_ds = 1'b0;
            ds_run  = 0;
        end else begin
            if (bus.done) begin
                done_count++;
                chk("model_result", 64'(bus.result), 64'(exp_r));
                chk("model_err", 64'(bus.err), 64'(exp_err));
            end
            if (bus.mm_ds) begin
                chk("mm_modulus", 64'(bus.mm_modulus), 64'(exp_n));
                if (prev_ds) begin
                    chk("mpand_stable", 64'(bus.mm_mpand), 64'(prev_a));
                    chk("mplier_stable", 64'(bus.mm_mplier), 64'(prev_b));
                end
                ds_run++;
                if (ds_run > ds_run_max) ds_run_max = ds_run;
            end else begin
                ds_run = 0;
            end
            prev_ds = bus.mm_ds;
            prev_a  = bus.mm_mpand;
            prev_b  = bus.mm_mplier;
        end
    end

    task automatic pulse_start(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
        exp_r   = model_exp(b, e, n);
        exp_err = (n == '0);
        exp_n   = n;
        bus.base     = b;
        bus.exponent = e;
        bus.modulus  = n;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n,
                       input logic [W-1:0] lit_r, input logic lit_err, input int lit_acc,
                       input int lit_lat, input bit repulse);
        int acc0, dc0, cycles;
        acc0 = accepts;
        dc0  = done_count;
        ds_run_max = 0;
        pulse_start(b, e, n);
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        cycles = 1;
        while (!bus.done && cycles < 3000) begin
            if (repulse && cycles == 3) begin
                bus.base = 3; bus.exponent = 5; bus.modulus = 7; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        chk("done_seen", 64'(bus.done), 64'd1);
        chk("result_lit", 64'(bus.result), 64'(lit_r));
        chk("err_lit", 64'(bus.err), 64'(lit_err));
        if (lit_lat > 0) chk("done_latency", 64'(cycles), 64'(lit_lat));
        chk("accepts_lit", 64'(accepts - acc0), 64'(lit_acc));
        chk("accepts_model", 64'(accepts - acc0), 64'(model_ops(e, n)));
        @(negedge clk);
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        chk("done_single", 64'(bus.done), 64'd0);
        chk("done_count", 64'(done_count - dc0), 64'd1);
        chk("result_hold", 64'(bus.result), 64'(lit_r));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int dc0, n;
        bus.start = 1'b0;
        bus.base = '0;
        bus.exponent = '0;
        bus.modulus = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_ds", 64'(bus.mm_ds), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_mpand", 64'(bus.mm_mpand), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 6, 0, 1'b0);
        run(16'd2, 16'hFFFF, 16'd65521, 16'd32768, 1'b0, 31, 0, 1'b0);
        run(16'd7, 16'd0, 16'd13, 16'd1, 1'b0, 0, 0, 1'b0);
        run(16'd0, 16'd5, 16'd1, 16'd0, 1'b0, 0, 0, 1'b0);
        run(16'd0, 16'd5, 16'd0, 16'd0, 1'b1, 0, 2, 1'b0);
        run(16'd3, 16'd2, 16'd11, 16'd9, 1'b0, 2, 0, 1'b0);
        run(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 6, 0, 1'b1);

        stall_req = 1'b1;
        run(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 6, 0, 1'b0);
        chk("stall_ds_cycles", 64'(ds_run_max), 64'd6);
        stall_req = 1'b0;

        // abandon a computation while a square is being issued
        dc0 = done_count;
        pulse_start(16'd4, 16'd13, 16'd497);
        n = 0;
        while (!(bus.mm_ds && bus.mm_mpand == bus.mm_mplier) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("square_reached", 64'(bus.mm_ds && bus.mm_mpand == bus.mm_mplier), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_ds", 64'(bus.mm_ds), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst_no_done", 64'(done_count - dc0), 64'd0);
        chk("midrst_idle", 64'(bus.busy), 64'd0);
        run(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 6, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
